// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and constants for the load/store unit: access
//               size codes (funct3), FSM states and the data window limits.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

   // funct3 access size codes
   typedef enum logic [2:0] {
      LB  = 3'd0,
      LH  = 3'd1,
      LW  = 3'd2,
      LBU = 3'd4,
      LHU = 3'd5
   } size_t;

   // LSU control states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RESP  = 2'd1,
      WRITE = 2'd2
   } state_t;

   // Data memory window (first byte, last word)
   localparam logic [31:0] DMEM_BASE = 32'h8100_0000;
   localparam logic [31:0] DMEM_LAST = 32'h8100_03FC;

endpackage
`default_nettype wire

// File: rtl/lsu_byte_lane.sv
`default_nettype none
// ============================================================================
// Module      : lsu_byte_lane
// Description : Combinational lane logic. Extracts and sign/zero extends the
//               addressed byte/half of a memory word for loads, and merges
//               store data into the addressed lane of a read-back word.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_byte_lane
   import lsu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       i_size,
   input  logic [1:0]       i_ofs,
   input  logic [WIDTH-1:0] i_rdata,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [WIDTH-1:0] i_merge,
   output logic [WIDTH-1:0] o_ld_data,
   output logic [WIDTH-1:0] o_st_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Load path: pick the lane, then extend according to the size code
   always_comb begin
      w_byte    = i_rdata[8*i_ofs +: 8];
      w_half    = i_rdata[16*i_ofs[1] +: 16];
      o_ld_data = '0;
      case (i_size)
         LB:      o_ld_data = {{(WIDTH-8){w_byte[7]}}, w_byte};
         LH:      o_ld_data = {{(WIDTH-16){w_half[15]}}, w_half};
         LW:      o_ld_data = i_rdata;
         LBU:     o_ld_data = {{(WIDTH-8){1'b0}}, w_byte};
         LHU:     o_ld_data = {{(WIDTH-16){1'b0}}, w_half};
         default: o_ld_data = '0;
      endcase
   end

   // Store path: overwrite only the addressed lane of the read-back word
   always_comb begin
      o_st_data = i_merge;
      case ({1'b0, i_size[1:0]})
         LB:      o_st_data[8*i_ofs +: 8]       = i_wdata[7:0];
         LH:      o_st_data[16*i_ofs[1] +: 16]  = i_wdata[15:0];
         default: o_st_data = i_wdata;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Load/store unit between execute stage and word-only data
//               memory. Window/alignment checks, 2-cycle loads with extension,
//               1-cycle word stores, 2-cycle read-modify-write sub-word stores.
//               Build option LSU_MISALIGN_TRAP_EN: misaligned accesses fault;
//               when undefined, low address bits are forced to alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] BASE_ADDR = DMEM_BASE,
   parameter logic [WIDTH-1:0] LAST_ADDR = DMEM_LAST
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             REQ,
   input  logic             WE,
   input  logic [2:0]       SIZE,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] WD,
   output logic [WIDTH-1:0] RD,
   output logic             STALL,
   output logic             FAULT,
   output logic             MEM_WE,
   output logic [WIDTH-1:0] MEM_A,
   output logic [WIDTH-1:0] MEM_WD,
   input  logic [WIDTH-1:0] MEM_RD
);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_merge;
   logic [WIDTH-1:0] w_ld_data;
   logic [WIDTH-1:0] w_st_data;
   logic [1:0]       w_ofs;
   logic             w_oow;
   logic             w_misalign;
   logic             w_bad_size;
   logic             w_fault;
   logic             w_ld_cap;
   logic             w_mg_cap;

   assign MEM_A = {A[WIDTH-1:2], 2'b00};

   // Address window, size-code and alignment checks; effective lane offset
   always_comb begin
      w_oow      = (A < BASE_ADDR) || (MEM_A > LAST_ADDR);
      w_bad_size = (SIZE == 3'd3) || (SIZE[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
      w_misalign = ((SIZE[1:0] == 2'd1) && A[0]) ||
                   ((SIZE[1:0] == 2'd2) && (A[1:0] != 2'b00));
      w_ofs      = A[1:0];
`else
      w_misalign = 1'b0;
      if (SIZE[1:0] == 2'd2)
         w_ofs = 2'b00;
      else if (SIZE[1:0] == 2'd1)
         w_ofs = {A[1], 1'b0};
      else
         w_ofs = A[1:0];
`endif
      w_fault    = w_oow || w_misalign || w_bad_size;
   end

   lsu_byte_lane #(
      .WIDTH     (WIDTH)
   ) u_lane (
      .i_size    (SIZE),
      .i_ofs     (w_ofs),
      .i_rdata   (MEM_RD),
      .i_wdata   (WD),
      .i_merge   (r_merge),
      .o_ld_data (w_ld_data),
      .o_st_data (w_st_data)
   );

   // Next-state and outputs; everything quiet while reset is asserted
   always_comb begin
      w_next   = r_state;
      STALL    = 1'b0;
      FAULT    = 1'b0;
      MEM_WE   = 1'b0;
      MEM_WD   = WD;
      w_ld_cap = 1'b0;
      w_mg_cap = 1'b0;
      if (RST_N) begin
         case (r_state)
            IDLE: begin
               if (REQ) begin
                  if (w_fault) begin
                     FAULT = 1'b1;
                  end else if (!WE) begin
                     STALL    = 1'b1;
                     w_ld_cap = 1'b1;
                     w_next   = RESP;
                  end else if (SIZE[1:0] == 2'd2) begin
                     MEM_WE = 1'b1;
                  end else begin
                     STALL    = 1'b1;
                     w_mg_cap = 1'b1;
                     w_next   = WRITE;
                  end
               end
            end
            RESP: begin
               w_next = IDLE;
            end
            WRITE: begin
               MEM_WE = 1'b1;
               MEM_WD = w_st_data;
               w_next = IDLE;
            end
            default: begin
               w_next = IDLE;
            end
         endcase
      end
   end

   // State, load result and merge registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= IDLE;
         RD      <= '0;
         r_merge <= '0;
      end else begin
         r_state <= w_next;
         if (w_ld_cap)
            RD <= w_ld_data;
         if (w_mg_cap)
            r_merge <= MEM_RD;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Scoreboard bench for load_store_unit with a word memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        REQ;
   logic        WE;
   logic [2:0]  SIZE;
   logic [31:0] A;
   logic [31:0] WD;
   logic [31:0] RD;
   logic        STALL;
   logic        FAULT;
   logic        MEM_WE;
   logic [31:0] MEM_A;
   logic [31:0] MEM_WD;
   logic [31:0] MEM_RD;

   typedef struct {
      logic        fault;
      logic        we;
      logic [31:0] wd;
      logic [31:0] a;
      logic        rd_chk;
      logic [31:0] rd;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mem [0:255];
   int          checks = 0;
   int          bad = 0;
   int          stalls = 0;

   load_store_unit dut (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .REQ    (REQ),
      .WE     (WE),
      .SIZE   (SIZE),
      .A      (A),
      .WD     (WD),
      .RD     (RD),
      .STALL  (STALL),
      .FAULT  (FAULT),
      .MEM_WE (MEM_WE),
      .MEM_A  (MEM_A),
      .MEM_WD (MEM_WD),
      .MEM_RD (MEM_RD)
   );

   always #5 CLK = ~CLK;

   // Data memory model: combinational read, synchronous write
   assign MEM_RD = mem[MEM_A[9:2]];
   always @(posedge CLK) begin
      if (MEM_WE)
         mem[MEM_A[9:2]] <= MEM_WD;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   function automatic exp_t mk(input logic f, input logic w, input logic [31:0] wd,
                               input logic [31:0] a, input logic rc,
                               input logic [31:0] rd, input int cyc);
      exp_t e;
      e.fault = f; e.we = w; e.wd = wd; e.a = a; e.rd_chk = rc; e.rd = rd; e.cyc = cyc;
      return e;
   endfunction

   // Drive one request, hold it until STALL drops, end one cycle later
   task automatic issue(input logic we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input exp_t e);
      logic done;
      done = 1'b0;
      exp_q.push_back(e);
      REQ = 1'b1; WE = we; SIZE = sz; A = a; WD = wd;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         if (!STALL) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         checks++;
         bad++;
         $display("FAIL timeout: request at %h never completed", a);
      end
      @(posedge CLK);
      #1;
   endtask

   // Monitor: a request completes in the cycle it is seen with STALL low
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (!RST_N) begin
            stalls = 0;
         end else if (REQ && STALL) begin
            stalls++;
         end else if (REQ) begin
            if (exp_q.size() == 0) begin
               checks++;
               bad++;
               $display("FAIL unexpected_completion: A=%h got none expected", A);
            end else begin
               e = exp_q.pop_front();
               chk("fault", {31'd0, FAULT}, {31'd0, e.fault});
               chk("mem_we", {31'd0, MEM_WE}, {31'd0, e.we});
               chk("stall_cycles", stalls, e.cyc);
               if (e.we) begin
                  chk("mem_wd", MEM_WD, e.wd);
                  chk("mem_a", MEM_A, e.a);
               end
               if (e.rd_chk)
                  chk("rd", RD, e.rd);
            end
            stalls = 0;
         end
      end
   end

   initial begin
      for (int i = 0; i < 256; i++)
         mem[i] = 32'd0;
      RST_N = 1'b0;
      REQ = 1'b1; WE = 1'b1; SIZE = 3'd2; A = 32'h8100_0000; WD = 32'h1234_8678;
      repeat (2) @(negedge CLK);
      chk("rst_mem_we", {31'd0, MEM_WE}, 32'd0);
      chk("rst_stall", {31'd0, STALL}, 32'd0);
      chk("rst_fault", {31'd0, FAULT}, 32'd0);
      chk("rst_rd", RD, 32'd0);
      @(posedge CLK);
      #1;
      RST_N = 1'b1;

      issue(1, 3'd2, 32'h8100_0000, 32'h1234_8678, mk(0, 1, 32'h1234_8678, 32'h8100_0000, 0, 0, 0));
      issue(1, 3'd2, 32'h8100_0010, 32'hDEAD_BEEF, mk(0, 1, 32'hDEAD_BEEF, 32'h8100_0010, 0, 0, 0));
      issue(0, 3'd0, 32'h8100_0013, 32'h0,         mk(0, 0, 0, 0, 1, 32'hFFFF_FFDE, 1));
      issue(0, 3'd4, 32'h8100_0013, 32'h0,         mk(0, 0, 0, 0, 1, 32'h0000_00DE, 1));
      issue(0, 3'd5, 32'h8100_0012, 32'h0,         mk(0, 0, 0, 0, 1, 32'h0000_DEAD, 1));
      issue(0, 3'd1, 32'h8100_0012, 32'h0,         mk(0, 0, 0, 0, 1, 32'hFFFF_DEAD, 1));
      issue(1, 3'd2, 32'h8100_0020, 32'h1122_3344, mk(0, 1, 32'h1122_3344, 32'h8100_0020, 0, 0, 0));
      issue(1, 3'd1, 32'h8100_0022, 32'hAAAA_BBBB, mk(0, 1, 32'hBBBB_3344, 32'h8100_0020, 0, 0, 1));
      issue(0, 3'd2, 32'h8100_0020, 32'h0,         mk(0, 0, 0, 0, 1, 32'hBBBB_3344, 1));
      issue(0, 3'd2, 32'h8100_0400, 32'h0,         mk(1, 0, 0, 0, 1, 32'hBBBB_3344, 0));
      issue(1, 3'd2, 32'h80FF_FFFC, 32'h5555_5555, mk(1, 0, 0, 0, 1, 32'hBBBB_3344, 0));
      issue(0, 3'd3, 32'h8100_0000, 32'h0,         mk(1, 0, 0, 0, 1, 32'hBBBB_3344, 0));
`ifdef LSU_MISALIGN_TRAP_EN
      issue(0, 3'd1, 32'h8100_0001, 32'h0,         mk(1, 0, 0, 0, 1, 32'hBBBB_3344, 0));
`else
      issue(0, 3'd1, 32'h8100_0001, 32'h0,         mk(0, 0, 0, 0, 1, 32'hFFFF_8678, 1));
`endif
      issue(1, 3'd0, 32'h8100_0001, 32'hFFFF_FF99, mk(0, 1, 32'h1234_9978, 32'h8100_0000, 0, 0, 1));
`ifdef LSU_MISALIGN_TRAP_EN
      issue(0, 3'd2, 32'h8100_0002, 32'h0,         mk(1, 0, 0, 0, 1, 32'hBBBB_3344, 0));
`else
      issue(0, 3'd2, 32'h8100_0002, 32'h0,         mk(0, 0, 0, 0, 1, 32'h1234_9978, 1));
`endif
      issue(1, 3'd2, 32'h8100_0004, 32'hCAFE_F00D, mk(0, 1, 32'hCAFE_F00D, 32'h8100_0004, 0, 0, 0));
      issue(0, 3'd2, 32'h8100_0004, 32'h0,         mk(0, 0, 0, 0, 1, 32'hCAFE_F00D, 1));

      // SB interrupted by reset while in the write state
      REQ = 1'b1; WE = 1'b1; SIZE = 3'd0; A = 32'h8100_0011; WD = 32'h0000_0055;
      @(negedge CLK);
      chk("sb_stall", {31'd0, STALL}, 32'd1);
      @(posedge CLK);
      #1;
      chk("sb_write_we", {31'd0, MEM_WE}, 32'd1);
      RST_N = 1'b0;
      #1;
      chk("rst_write_we", {31'd0, MEM_WE}, 32'd0);
      @(negedge CLK);
      chk("rst_write_stall", {31'd0, STALL}, 32'd0);
      chk("rst_write_rd", RD, 32'd0);
      @(posedge CLK);
      #1;
      REQ = 1'b0;
      RST_N = 1'b1;
      @(posedge CLK);
      #1;
      chk("mem_unchanged", mem[4], 32'hDEAD_BEEF);
      issue(0, 3'd2, 32'h8100_0010, 32'h0,         mk(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1));
      issue(0, 3'd1, 32'h8100_0010, 32'h0,         mk(0, 0, 0, 0, 1, 32'hFFFF_BEEF, 1));

      REQ = 1'b0;
      repeat (3) @(negedge CLK);
      chk("idle_mem_we", {31'd0, MEM_WE}, 32'd0);
      chk("idle_rd_hold", RD, 32'hFFFF_BEEF);
      chk("queue_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", checks, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core execute stage and data memory. The data memory has word-only access, a combinational read and a synchronous write, and decodes its own address window.
- Accepts load/store requests of byte, half or word size and performs address window and alignment checks.
- Sub-word stores are done as read-modify-write. Loads are sign- or zero-extended into a registered result.
- Stalls the core with STALL while a multi-cycle access is in flight.

Parameters:
- WIDTH, 32, data/address width
- BASE_ADDR, 32'h8100_0000, first valid byte address of the data window
- LAST_ADDR, 32'h8100_03FC, last valid word address of the data window

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- REQ  in  1  core access request; core holds REQ/WE/SIZE/A/WD stable while STALL=1
- WE  in  1  1=store, 0=load
- SIZE  in  3  funct3 code: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU
- A  in  WIDTH  byte address
- WD  in  WIDTH  store data, right-aligned
- RD  out  WIDTH  registered, extended load result
- STALL  out  1  core must hold the request and not advance
- FAULT  out  1  one-cycle pulse: out-of-window or misaligned access
- MEM_WE  out  1  data memory write enable
- MEM_A  out  WIDTH  word-aligned memory address ({A[WIDTH-1:2],2'b00})
- MEM_WD  out  WIDTH  memory write data
- MEM_RD  in  WIDTH  memory combinational read data

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, RD=0, merge register=0, MEM_WE=0. STALL=0 and FAULT=0 while RST_N=0.
- Reset mid-operation: return to IDLE; the pending write is never issued.
- Fault check in IDLE with REQ=1:
  - out_of_window = A<BASE_ADDR or {A[31:2],2'b00}>LAST_ADDR.
  - misaligned = (SIZE[1:0]==1 and A[0]) or (SIZE[1:0]==2 and A[1:0]!=0).
  - SIZE values 3, 6, 7 are treated as faults.
  - On any fault: FAULT=1 for that cycle, STALL=0, MEM_WE=0, RD unchanged, stay in IDLE.
- IDLE, valid load: STALL=1. Capture the extracted, extended MEM_RD into RD at the clock edge. Go to RESP.
- RESP: STALL=0, RD valid, go to IDLE. Load latency is 2 cycles, so the core samples RD in the cycle STALL drops.
- IDLE, valid SW: MEM_WE=1, MEM_WD=WD, STALL=0. Completes in 1 cycle.
- IDLE, valid SB/SH: STALL=1. Capture MEM_RD into the merge register. Go to WRITE.
- WRITE: MEM_WE=1, MEM_WD = merge register with lane A[1:0] (byte) or A[1] (half) replaced by WD[7:0]/WD[15:0]. STALL=0. Go to IDLE.
- Extraction and extension:
  - Byte lane = MEM_RD[8*A[1:0] +: 8]; half lane = MEM_RD[16*A[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes MEM_RD through.
- REQ=0 in IDLE: no memory write, STALL=0, RD holds its value.
- Back-to-back requests: a new request is accepted in the cycle after completion (IDLE). There are no idle bubbles beyond those listed.
- MEM_A is always driven from A, including in non-IDLE states, because A is held stable.

Optional Feature:
- LSU_MISALIGN_TRAP_EN
- Defined: misalignment raises FAULT as above.
- Undefined: misalignment never faults. Low address bits are forced to natural alignment: A[0] is cleared for half accesses and A[1:0] is cleared for word accesses. Out-of-window accesses still fault.

Decomposition:
- Package lsu_pkg holds:
  - enum size_t (LB=0, LH=1, LW=2, LBU=4, LHU=5)
  - enum state_t (IDLE, RESP, WRITE)
  - DMEM_BASE/DMEM_LAST constants, used as parameter defaults
- One sub-module, lsu_byte_lane: purely combinational extract/extend for loads and lane-merge for stores. Instantiated once; the FSM lives in load_store_unit.

Test Plan:
- Reset with REQ=1, WE=1, SIZE=2 held → MEM_WE=0, STALL=0, RD=0. After release, SW completes in 1 cycle.
- SW A=0x8100_0010 WD=0xDEADBEEF, then LB A=0x8100_0013 → STALL high 1 cycle, RD=0xFFFF_FFDE. Then LBU same address → RD=0x0000_00DE.
- Word 0x8100_0020=0x1122_3344, SH A=0x8100_0022 WD=0xAAAA_BBBB → 2 cycles (STALL 1 then 0), MEM_WD=0xBBBB_3344 with MEM_WE=1 in the second cycle. LW then returns 0xBBBB_3344.
- LW A=0x8100_0400 and SW A=0x80FF_FFFC → FAULT pulse 1 cycle each, MEM_WE=0, RD unchanged.
- LH A=0x8100_0001: with LSU_MISALIGN_TRAP_EN → FAULT=1, no stall. Without it → behaves as LH 0x8100_0000.
- SB issued, RST_N pulsed low in the WRITE state → no MEM_WE observed, memory word unchanged, FSM returns to IDLE.
